// File: rtl/dm_bridge.sv
// dm_bridge: data-side responder for the CPU M-stage data port.
// Decodes each access to a byte-writable word data memory, to a
// memory-mapped countdown timer (CTRL +0, PRESET +4, COUNT +8), or to
// unmapped space. Read data is returned in the same cycle.
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous, active-low reset (timer state only)
//   m_data_addr    byte address; bits [1:0] ignored for decode
//   m_data_wdata   lane-aligned write data
//   m_data_byteen  byte write enables; 4'b0000 = read / idle
//   m_data_rdata   combinational read data
//   irq            timer interrupt request (irq_pend masked by im)
//   addr_err       combinational flag for an illegal write this cycle
module dm_bridge #(
  parameter int unsigned DM_WORDS   = 3072,
  parameter logic [31:0] TIMER_BASE = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m_data_addr,
  input  logic [31:0] m_data_wdata,
  input  logic [3:0]  m_data_byteen,
  output logic [31:0] m_data_rdata,
  output logic        irq,
  output logic        addr_err
);

  localparam int unsigned IDX_W    = (DM_WORDS > 1) ? $clog2(DM_WORDS) : 1;
  localparam logic [29:0] DM_LIMIT = 30'(DM_WORDS);
  localparam logic [29:0] W_CTRL   = TIMER_BASE[31:2];
  localparam logic [29:0] W_PRESET = W_CTRL + 30'd1;
  localparam logic [29:0] W_COUNT  = W_CTRL + 30'd2;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CNT, S_INT} state_t;

  state_t      state;
  state_t      state_nxt;

  logic [31:0] mem [DM_WORDS];

  logic        ctrl_en;
  logic        ctrl_im;
  logic [1:0]  ctrl_mode;
  logic [31:0] preset;
  logic [31:0] count;
  logic        irq_pend;

  logic [29:0]      word;
  logic [IDX_W-1:0] dm_idx;
  logic             wr;
  logic             full;
  logic             dm_hit;
  logic             ctrl_hit;
  logic             preset_hit;
  logic             count_hit;
  logic             timer_hit;
  logic             dm_we;
  logic             ctrl_we;
  logic             preset_we;

  logic load_cnt;
  logic dec_cnt;
  logic set_pend;
  logic clr_pend;
  logic clr_en;

  // Address decode. Data memory takes priority should the two ranges
  // ever be parameterised to overlap.
  assign word       = m_data_addr[31:2];
  assign dm_idx     = word[IDX_W-1:0];
  assign wr         = |m_data_byteen;
  assign full       = (m_data_byteen == 4'b1111);
  assign dm_hit     = (word < DM_LIMIT);
  assign ctrl_hit   = !dm_hit && (word == W_CTRL);
  assign preset_hit = !dm_hit && (word == W_PRESET);
  assign count_hit  = !dm_hit && (word == W_COUNT);
  assign timer_hit  = ctrl_hit || preset_hit || count_hit;

  assign dm_we     = wr && dm_hit;
  assign ctrl_we   = wr && full && ctrl_hit;
  assign preset_we = wr && full && preset_hit;

  // Timer registers only take full-word writes and COUNT is read-only.
  assign addr_err = wr && !dm_hit && (!timer_hit || !full || count_hit);

  always_comb begin
    m_data_rdata = 32'b0;
    if (dm_hit)          m_data_rdata = mem[dm_idx];
    else if (ctrl_hit)   m_data_rdata = {28'b0, ctrl_im, ctrl_mode, ctrl_en};
    else if (preset_hit) m_data_rdata = preset;
    else if (count_hit)  m_data_rdata = count;
  end

  // Data memory: never reset, byte-lane writes.
  always_ff @(posedge clk) begin
    if (dm_we) begin
      for (int i = 0; i < 4; i++) begin
        if (m_data_byteen[i]) mem[dm_idx][8*i +: 8] <= m_data_wdata[8*i +: 8];
      end
    end
  end

  // Timer FSM: state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Timer FSM: next state.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (ctrl_en) state_nxt = S_LOAD;
      S_LOAD:  state_nxt = S_CNT;
      S_CNT: begin
        if (!ctrl_en)          state_nxt = S_IDLE;
        else if (count == '0)  state_nxt = S_INT;
      end
      S_INT:   state_nxt = (ctrl_mode == 2'b01) ? S_LOAD : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Timer FSM: actions requested of the datapath.
  always_comb begin
    load_cnt = 1'b0;
    dec_cnt  = 1'b0;
    set_pend = 1'b0;
    clr_pend = 1'b0;
    clr_en   = 1'b0;
    case (state)
      S_LOAD: load_cnt = 1'b1;
      S_CNT: begin
        dec_cnt  = ctrl_en && (count != '0);
        set_pend = ctrl_en && (count == '0);
      end
      S_INT: begin
        // Auto-reload makes irq_pend a one-cycle pulse; every other mode
        // is one-shot and leaves irq_pend for software to clear.
        clr_pend = (ctrl_mode == 2'b01);
        clr_en   = (ctrl_mode != 2'b01);
      end
      default: ;
    endcase
  end

  // Timer registers. A CPU write to CTRL outranks the FSM on both en and
  // irq_pend; a PRESET write only matters at the next LOAD.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_en   <= 1'b0;
      ctrl_mode <= 2'b00;
      ctrl_im   <= 1'b0;
      preset    <= 32'b0;
      count     <= 32'b0;
      irq_pend  <= 1'b0;
    end else begin
      if (ctrl_we)     {ctrl_im, ctrl_mode, ctrl_en} <= m_data_wdata[3:0];
      else if (clr_en) ctrl_en <= 1'b0;

      if (preset_we) preset <= m_data_wdata;

      if (load_cnt)     count <= preset;
      else if (dec_cnt) count <= count - 32'd1;

      if (ctrl_we)       irq_pend <= 1'b0;
      else if (set_pend) irq_pend <= 1'b1;
      else if (clr_pend) irq_pend <= 1'b0;
    end
  end

  assign irq = irq_pend & ctrl_im;

endmodule

// File: tb/tb_dm_bridge.sv
// Self-checking bench for dm_bridge: directed timer scenarios with timing
// expectations derived from the timer's cycle rules, plus randomized data
// memory traffic checked against a word-array reference.
module tb_dm_bridge;

  localparam int          DM_WORDS = 3072;
  localparam logic [31:0] TBASE    = 32'h0000_7F00;
  localparam logic [31:0] A_CTRL   = TBASE;
  localparam logic [31:0] A_PRESET = TBASE + 32'd4;
  localparam logic [31:0] A_COUNT  = TBASE + 32'd8;
  localparam logic [31:0] A_BYTES  = 32'h0000_0080;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  byteen;
  logic [31:0] rdata;
  logic        irq;
  logic        addr_err;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [31:0] ref_mem [64];

  dm_bridge #(.DM_WORDS(DM_WORDS), .TIMER_BASE(TBASE)) dut (
    .clk           (clk),
    .reset         (reset),
    .m_data_addr   (addr),
    .m_data_wdata  (wdata),
    .m_data_byteen (byteen),
    .m_data_rdata  (rdata),
    .irq           (irq),
    .addr_err      (addr_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_irq(input string tag, input logic exp);
    check(tag, {31'b0, irq}, {31'b0, exp});
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Drive one write; addr_err is sampled before the edge that commits it.
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                    input logic err, input string tag);
    addr = a; wdata = d; byteen = be;
    #1;
    check({tag, "_err"}, {31'b0, addr_err}, {31'b0, err});
    @(posedge clk);
    #1;
    byteen = 4'b0000;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
    addr = a; byteen = 4'b0000;
    #1;
    check(tag, rdata, exp);
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] be);
    logic [31:0] mask;
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (old & ~mask) | (d & mask);
  endfunction

  // One-shot with im=1: irq from t+3+N onward, COUNT = N-(k-2) then 0,
  // en self-clears one cycle after INT; CTRL=0 written at edge t+clr.
  task automatic run_oneshot(input int n, input int clr);
    int t;
    int k;
    wr(A_PRESET, 32'(n), 4'hF, 1'b0, "os_preset");
    wr(A_CTRL, 32'h9, 4'hF, 1'b0, "os_ctrl");
    t = cyc;
    k = 0;
    while (k < clr - 1) begin
      cycle();
      k = cyc - t;
      chk_irq("os_irq", (k >= 3 + n));
      if (k >= 2) rd(A_COUNT, (k - 2 <= n) ? 32'(n - (k - 2)) : 32'd0, "os_count");
      rd(A_CTRL, (k >= 4 + n) ? 32'h8 : 32'h9, "os_ctrl_rd");
    end
    wr(A_CTRL, 32'h0, 4'hF, 1'b0, "os_clear");
    chk_irq("os_irq_clr", 1'b0);
    rd(A_COUNT, 32'd0, "os_count_end");
    rd(A_CTRL, 32'd0, "os_ctrl_end");
  endtask

  // Auto-reload: INT at t+3+N and every N+3 cycles after; COUNT phase
  // p=(k-2) mod (N+3) reads N-p for p<=N, else 0 (INT and LOAD cycles).
  task automatic run_reload(input int n, input logic im, input int cycles);
    int t;
    int k;
    int p;
    logic [31:0] cv;
    cv = {28'b0, im, 3'b011};
    wr(A_PRESET, 32'(n), 4'hF, 1'b0, "ar_preset");
    wr(A_CTRL, cv, 4'hF, 1'b0, "ar_ctrl");
    t = cyc;
    for (int j = 1; j <= cycles; j++) begin
      cycle();
      k = cyc - t;
      chk_irq("ar_irq", im && (k >= 3 + n) && (((k - 3 - n) % (n + 3)) == 0));
      if (k >= 2) begin
        p = (k - 2) % (n + 3);
        rd(A_COUNT, (p <= n) ? 32'(n - p) : 32'd0, "ar_count");
      end
      rd(A_CTRL, cv, "ar_ctrl_rd");
    end
    wr(A_CTRL, 32'h0, 4'hF, 1'b0, "ar_stop");
    repeat (n + 4) cycle();
    chk_irq("ar_irq_idle", 1'b0);
  endtask

  initial begin
    int t;
    int idx;
    int n;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;

    reset = 1'b0; addr = '0; wdata = '0; byteen = '0;

    // Reset state.
    #3;
    chk_irq("rst_irq", 1'b0);
    rd(A_CTRL, 32'd0, "rst_ctrl");
    rd(A_PRESET, 32'd0, "rst_preset");
    rd(A_COUNT, 32'd0, "rst_count");
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    cycle();

    // Byte lanes.
    wr(32'h10, 32'h1122_3344, 4'b1111, 1'b0, "lane_full");
    wr(32'h10, 32'hAA99_88BB, 4'b1001, 1'b0, "lane_part");
    rd(32'h10, 32'hAA22_33BB, "lane_rd");
    rd(32'h13, 32'hAA22_33BB, "lane_rd_lowbits");

    // Data memory boundary.
    wr(32'h2FFC, 32'hCAFE_F00D, 4'b1111, 1'b0, "dm_last");
    rd(32'h2FFF, 32'hCAFE_F00D, "dm_last_rd");
    wr(32'h3000, 32'h1234_5678, 4'b1111, 1'b1, "unm_3000");
    rd(32'h3000, 32'd0, "unm_3000_rd");
    wr(32'h3000, 32'h1234_5678, 4'b0000, 1'b0, "unm_idle");

    // Randomized data memory traffic on words 0x80..0x17C.
    for (int i = 0; i < 64; i++) begin
      d = $urandom;
      ref_mem[i] = d;
      wr(A_BYTES + 32'(i) * 32'd4, d, 4'hF, 1'b0, "dm_init");
    end
    for (int i = 0; i < 150; i++) begin
      idx = int'($urandom_range(0, 63));
      a = A_BYTES + 32'(idx) * 32'd4 + $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 1) begin
        d  = $urandom;
        be = 4'($urandom_range(0, 15));
        wr(a, d, be, 1'b0, "dm_wr");
        ref_mem[idx] = merge(ref_mem[idx], d, be);
      end else begin
        rd(a, ref_mem[idx], "dm_rd");
      end
    end
    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(0, 1) == 1) a = $urandom_range(32'h0000_3000, 32'h0000_7EFF);
      else                           a = $urandom_range(32'h0000_7F0C, 32'hFFFF_FFFF);
      wr(a, $urandom, 4'hF, 1'b1, "unm_rand");
      rd(a, 32'd0, "unm_rand_rd");
    end

    // Timer register access rules.
    wr(A_PRESET, 32'h1234_5678, 4'hF, 1'b0, "preset_wr");
    rd(A_PRESET + 32'd2, 32'h1234_5678, "preset_rd");
    wr(A_PRESET, 32'h0000_DEAD, 4'b0011, 1'b1, "preset_part");
    rd(A_PRESET, 32'h1234_5678, "preset_kept");
    wr(A_COUNT, 32'd5, 4'hF, 1'b1, "count_wr");
    rd(A_COUNT, 32'd0, "count_kept");
    wr(A_CTRL, 32'h1, 4'b0001, 1'b1, "ctrl_part");
    rd(A_CTRL, 32'd0, "ctrl_kept");
    wr(TBASE + 32'd12, 32'h1, 4'hF, 1'b1, "timer_past");

    // One-shot: directed N=5 with clear at t+12, then random N incl. 0.
    run_oneshot(5, 12);
    for (int i = 0; i < 3; i++) begin
      n = int'($urandom_range(0, 6));
      run_oneshot(n, n + 6);
    end
    run_oneshot(0, 6);

    // Auto-reload, and masked auto-reload.
    run_reload(2, 1'b1, 16);
    run_reload(int'($urandom_range(0, 4)), 1'b1, 20);
    run_reload(2, 1'b0, 12);

    // CTRL write on the edge irq_pend would be set: the clear wins.
    wr(A_PRESET, 32'd3, 4'hF, 1'b0, "sim1_preset");
    wr(A_CTRL, 32'h9, 4'hF, 1'b0, "sim1_ctrl");
    t = cyc;
    while (cyc - t < 5) cycle();
    wr(A_CTRL, 32'h9, 4'hF, 1'b0, "sim1_rewrite");
    chk_irq("sim1_irq_a", 1'b0);
    cycle();
    chk_irq("sim1_irq_b", 1'b0);
    rd(A_CTRL, 32'h8, "sim1_ctrl_rd");
    wr(A_CTRL, 32'h0, 4'hF, 1'b0, "sim1_off");

    // CTRL write on the FSM's en-clear edge: the CPU value wins.
    wr(A_PRESET, 32'd2, 4'hF, 1'b0, "sim2_preset");
    wr(A_CTRL, 32'h9, 4'hF, 1'b0, "sim2_ctrl");
    t = cyc;
    while (cyc - t < 5) cycle();
    chk_irq("sim2_int", 1'b1);
    wr(A_CTRL, 32'h9, 4'hF, 1'b0, "sim2_rewrite");
    t = cyc;
    rd(A_CTRL, 32'h9, "sim2_ctrl_rd");
    chk_irq("sim2_irq_clr", 1'b0);
    while (cyc - t < 4) cycle();
    chk_irq("sim2_irq_k4", 1'b0);
    cycle();
    chk_irq("sim2_irq_k5", 1'b1);
    wr(A_CTRL, 32'h0, 4'hF, 1'b0, "sim2_off");

    // Disable mid-count: COUNT holds 3.
    wr(A_PRESET, 32'd10, 4'hF, 1'b0, "dis_preset");
    wr(A_CTRL, 32'h9, 4'hF, 1'b0, "dis_ctrl");
    t = cyc;
    while (cyc - t < 8) cycle();
    rd(A_COUNT, 32'd4, "dis_count_k8");
    wr(A_CTRL, 32'h0, 4'hF, 1'b0, "dis_off");
    rd(A_COUNT, 32'd3, "dis_count_k9");
    repeat (4) begin
      cycle();
      rd(A_COUNT, 32'd3, "dis_hold");
      chk_irq("dis_irq", 1'b0);
    end

    // PRESET write during CNT applies at the next LOAD only.
    wr(A_PRESET, 32'd4, 4'hF, 1'b0, "pl_preset");
    wr(A_CTRL, 32'hB, 4'hF, 1'b0, "pl_ctrl");
    t = cyc;
    while (cyc - t < 3) cycle();
    wr(A_PRESET, 32'd1, 4'hF, 1'b0, "pl_new");
    rd(A_COUNT, 32'd2, "pl_count_k4");
    while (cyc - t < 6) cycle();
    rd(A_COUNT, 32'd0, "pl_count_k6");
    cycle();
    chk_irq("pl_irq_k7", 1'b1);
    while (cyc - t < 9) cycle();
    rd(A_COUNT, 32'd1, "pl_count_k9");
    wr(A_CTRL, 32'h0, 4'hF, 1'b0, "pl_off");
    repeat (6) cycle();

    // Full-range PRESET counts down normally.
    wr(A_PRESET, 32'hFFFF_FFFF, 4'hF, 1'b0, "big_preset");
    wr(A_CTRL, 32'h1, 4'hF, 1'b0, "big_ctrl");
    t = cyc;
    while (cyc - t < 2) cycle();
    rd(A_COUNT, 32'hFFFF_FFFF, "big_k2");
    while (cyc - t < 5) cycle();
    rd(A_COUNT, 32'hFFFF_FFFC, "big_k5");
    wr(A_CTRL, 32'h0, 4'hF, 1'b0, "big_off");
    repeat (3) cycle();

    // Asynchronous reset while irq is high.
    wr(A_PRESET, 32'd1, 4'hF, 1'b0, "rm_preset");
    wr(A_CTRL, 32'h9, 4'hF, 1'b0, "rm_ctrl");
    t = cyc;
    while (cyc - t < 5) cycle();
    chk_irq("rm_irq_hi", 1'b1);
    #2 reset = 1'b0;
    #1;
    chk_irq("rm_irq_lo", 1'b0);
    rd(A_CTRL, 32'd0, "rm_ctrl_rd");
    rd(A_PRESET, 32'd0, "rm_preset_rd");
    rd(A_COUNT, 32'd0, "rm_count_rd");
    rd(32'h10, 32'hAA22_33BB, "rm_dm_kept");
    cycle();
    chk_irq("rm_irq_held", 1'b0);
    #2 reset = 1'b1;
    cycle();
    chk_irq("rm_irq_after", 1'b0);
    rd(A_CTRL, 32'd0, "rm_ctrl_after");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dm_bridge.md
# dm_bridge

Data-side bus responder for the pipelined CPU. It answers the CPU's M-stage data port (`m_data_addr`, `m_data_wdata`, `m_data_byteen`) and returns `m_data_rdata` in the same cycle, so the CPU's load path needs no stall. It decodes each access to one of two targets: a byte-writable word data memory, or a memory-mapped countdown timer that raises `irq`.

## Interface
- `DM_WORDS`, 3072, data-memory depth in 32-bit words; occupies byte range 0 .. DM_WORDS*4-1.
- `TIMER_BASE`, 32'h0000_7F00, base byte address of the timer registers (CTRL +0, PRESET +4, COUNT +8).
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `m_data_addr` input 32: byte address from the CPU M stage; bits [1:0] ignored for decode.
- `m_data_wdata` input 32: write data, already lane-aligned by the CPU.
- `m_data_byteen` input 4: byte write enables; 4'b0000 means no write (read or idle).
- `m_data_rdata` output 32: combinational read data for `m_data_addr`.
- `irq` output 1: timer interrupt request, registered.
- `addr_err` output 1: combinational; flags an illegal write in the current cycle.

## Operation
- **Decode.** Word index is `m_data_addr[31:2]`. The target is one of:
  - DM, if addr < DM_WORDS*4;
  - TIMER, if addr is in TIMER_BASE .. TIMER_BASE+11;
  - otherwise unmapped.
- **DM read.** `m_data_rdata` = mem[index], combinational.
- **DM write.** On the edge, each byte lane i with byteen[i]=1 is written from wdata[8i+7:8i]; other lanes keep their value.
- **DM reset.** DM contents are not affected by reset.
- **Unmapped access.** Reads return 0. Writes are dropped and `addr_err`=1.
- **Timer reads.**
  - CTRL returns {28'b0, im, mode[1:0], en}.
  - PRESET returns the 32-bit reload value.
  - COUNT returns the current count.
- **Timer writes.**
  - Only byteen=4'b1111 is accepted. Any other nonzero byteen is dropped with `addr_err`=1.
  - A write to COUNT is always dropped with `addr_err`=1.
  - Any write to CTRL clears `irq_pend`.
- **Timer FSM: IDLE, LOAD, CNT, INT.**
  - IDLE: if en=1, go to LOAD.
  - LOAD: COUNT <= PRESET; go to CNT.
  - CNT: if en=0, go to IDLE and hold COUNT. Else if COUNT==0, go to INT and set `irq_pend`. Else COUNT <= COUNT-1.
  - INT, mode 00 (one-shot): clear en, go to IDLE; `irq_pend` holds until the next CTRL write.
  - INT, mode 01 (auto-reload): go to LOAD and clear `irq_pend` (one-cycle pulse).
  - INT, modes 1x: behave as 00.
- **Interrupt output.** `irq` = `irq_pend` & im.
- **Simultaneous events.**
  - A CPU write to CTRL on the same edge as the FSM's own en-clear in INT: the CPU value wins.
  - A CPU write to CTRL on the same edge `irq_pend` would be set: the CTRL write's clear wins.
  - A PRESET write during CNT takes effect at the next LOAD only.
- **Wrap-around.** COUNT never decrements below 0. PRESET = 32'hFFFF_FFFF counts normally.

## Timing
- **Reset values.** While `reset`=0: CTRL=0, PRESET=0, COUNT=0, FSM=IDLE, `irq_pend`=0, `irq`=0. `m_data_rdata` and `addr_err` stay combinational from the inputs.
- **Read latency.** 0 cycles.
- **Write-to-read.** A write at edge t is visible to a read in the cycle after t.
- **Timer sequence** for a CTRL write with en=1 and PRESET=N at edge t:
  - LOAD at t+1;
  - COUNT=N at t+2;
  - COUNT=0 at t+2+N;
  - INT and `irq`=1 (if im) from t+3+N.
- **Auto-reload.** `irq` drops at t+4+N and COUNT=N again at t+5+N. Period is N+3 cycles.
- **N=0.** INT at t+3.
- **Reset mid-count.** Asserting reset during CNT or INT returns to IDLE immediately, asynchronously, with `irq`=0.

## Test plan
- **DM byte lanes.** Write 32'h1122_3344 to addr 0x10 with byteen 4'b1111, then 32'hAAxx_xxBB with byteen 4'b1001. Read 0x10 -> 32'hAA22_33BB.
- **Unmapped write.** Write 0x3000 (DM_WORDS=3072) with byteen 4'b1111 -> `addr_err`=1 that cycle and read returns 0. Write to TIMER_BASE+8 -> `addr_err`=1 and COUNT unchanged.
- **One-shot.** PRESET=5, CTRL=4'b1001 at edge t -> `irq` rises at t+8 and stays high. A CTRL write of 0 at t+12 -> `irq`=0 at t+13; COUNT reads 0.
- **Auto-reload.** PRESET=2, CTRL=4'b1011 -> `irq` pulses exactly one cycle every 5 cycles; COUNT sequence 2,1,0,x(INT),x(LOAD),2.
- **Disable and mask.** A CTRL write with en=0 while COUNT=3 -> COUNT holds 3 and FSM reaches IDLE. With im=0, INT occurs but `irq` stays 0 and reading CTRL shows the unmasked configuration.
- **Reset mid-operation.** Assert reset asynchronously while `irq`=1 -> `irq`=0 and CTRL/PRESET/COUNT=0 before the next clock edge. DM word 0x10 still reads its pre-reset value.
